decimator_10x: RTL
==================

DECIMATOR_10X -- requirements
Module: decimator_10x

Interface
REQ-001 The module SHALL have no parameters; the 10-entry coefficient table is fixed (REQ-012).
REQ-002 The port `clk` SHALL be an input, 1 bit wide, and is the single clock; all state SHALL update on its rising edge.
REQ-003 The port `reset` SHALL be an input, 1 bit wide, and is the reset: asynchronous, active-low.
REQ-004 The port `clk_en` SHALL be an input, 1 bit wide, and is the output-rate strobe; it closes one frame and opens the next.
REQ-005 The port `clk_en_10x` SHALL be an input, 1 bit wide, and is the input-rate strobe: one input sample per high cycle, phase-aligned with `clk_en`.
REQ-006 The port `sample_x` SHALL be an input, 8 bits wide, and is an unsigned input sample, sampled when `clk_en_10x` is high.
REQ-007 The port `sample_y` SHALL be an output, 8 bits wide, and is the unsigned decimated sample, registered and held between updates.
REQ-008 The port `valid` SHALL be an output, 1 bit wide, and is a one-cycle pulse when `sample_y` is updated.
REQ-009 The port `frame_err` SHALL be an output, 1 bit wide, and is a one-cycle pulse coincident with `valid` when the closed frame did not hold exactly 10 samples.

Function
REQ-010 The block SHALL keep a 4-bit sample counter `cnt` that saturates at 15, a 16-bit accumulator `acc` and a `primed` flag.
REQ-011 On a cycle with `clk_en_10x`=1, `clk_en`=0 and `cnt`<10, the block SHALL set `acc` to `acc` + `sample_x` × coef[`cnt`] and increment `cnt`.
REQ-012 The coefficient table coef[0..9] SHALL be 8,16,24,32,48,48,32,24,16,8, which sums to 256; a 6-bit unsigned width is sufficient.
REQ-013 On a cycle with `clk_en_10x`=1, `clk_en`=0 and `cnt`>=10, the block SHALL ignore the sample for accumulation and SHALL still increment `cnt` (saturating at 15).
REQ-014 On a cycle with `clk_en`=1, the block SHALL close the frame, and on the next clock edge:
- `sample_y` <= result(`acc`) (see REQ-020)
- `frame_err` <= (`cnt` != 10), when `primed`=1
- `valid` <= `primed`
- `primed` <= 1
REQ-015 On a cycle with `clk_en`=1 and `clk_en_10x`=1 together, the block SHALL load `acc` with `sample_x` × coef[0] and set `cnt` to 1; the sample is phase 0 of the new frame.
REQ-016 On a cycle with `clk_en`=1 and `clk_en_10x`=0, the block SHALL clear `acc` to 0 and set `cnt` to 0.
REQ-017 The latency from a `clk_en` cycle to `valid`/`sample_y` SHALL be exactly 1 clock; `valid` and `frame_err` SHALL be low on every other cycle.
REQ-018 The first `clk_en` after reset SHALL produce no `valid` and no `frame_err`; it only primes the block.
REQ-019 `acc` SHALL NOT overflow: its maximum value is 255×256 = 65280, and with the rounding constant it is 65408, below 2^16.
REQ-020 With DECIMATOR_10X_ROUND_EN defined, result(`acc`) SHALL be (`acc`+128)>>8; without it, result(`acc`) SHALL be `acc`>>8 (truncation); with either form the result is at most 255.

Reset
REQ-021 While `reset`=0, the block SHALL immediately (asynchronously) drive `sample_y`=0, `valid`=0 and `frame_err`=0, and clear `acc`=0, `cnt`=0 and `primed`=0.
REQ-022 A reset asserted mid-frame SHALL discard the partial frame, and the first `clk_en` after release SHALL only prime the block.
REQ-023 Release of `reset` SHALL take effect on the next `clk` edge, and the block SHALL not require a reset synchronizer internally.

Configuration
REQ-024 The macro DECIMATOR_10X_ROUND_EN SHALL be the single compile-time option: when defined it selects round-half-up per REQ-020, and when undefined it selects truncation with no adder in the output path.
REQ-025 All other behaviour SHALL be identical whether or not DECIMATOR_10X_ROUND_EN is defined.

Verification
REQ-026 A bench SHALL drive `sample_x`=100 constant, with 10 `clk_en_10x` per `clk_en`, and SHALL expect from the second frame on `sample_y`=100, `valid` pulsing, and `frame_err`=0 (either macro setting).
REQ-027 A bench SHALL drive `sample_x`=255 constant and SHALL expect `sample_y`=255 with no wrap (`acc`=65280).
REQ-028 A bench SHALL drive an impulse of 255 at phase 4 with all other samples 0 and SHALL expect `sample_y`=48 with ROUND_EN and 47 without.
REQ-029 A bench SHALL drive a short frame (9 samples) and a long frame (12 samples, where samples 11 and 12 are 255 and the rest 0) and SHALL expect `frame_err`=1 with `valid` for each; the long frame SHALL have `sample_y`=0.
REQ-030 A bench SHALL drive the first `clk_en` after reset and SHALL expect no `valid`.
REQ-031 A bench SHALL assert `reset` low for 3 cycles mid-frame and SHALL expect all outputs 0 at once, and the next `clk_en` SHALL produce no `valid`.

Source files
------------

// File: rtl/decimator_10x.sv
// 10:1 FIR decimator: weighted sum of ten input-rate samples per output frame.
// Compile-time option: DECIMATOR_10X_ROUND_EN selects round-half-up on the
// output; when undefined the output is the truncated accumulator.
module decimator_10x (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       clk_en_10x,
  input  logic [7:0] sample_x,
  output logic [7:0] sample_y,
  output logic       valid,
  output logic       frame_err
);

  localparam int unsigned X_W    = 8;
  localparam int unsigned COEF_W = 6;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(10);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(15);
  localparam logic [ACC_W-1:0] ROUND_K   = ACC_W'(128);

  // Fixed symmetric taps; they sum to 256 so the output is a >>8 of acc.
  function automatic logic [COEF_W-1:0] coef(input logic [CNT_W-1:0] idx);
    logic [COEF_W-1:0] c;
    case (idx)
      CNT_W'(0): c = COEF_W'(8);
      CNT_W'(1): c = COEF_W'(16);
      CNT_W'(2): c = COEF_W'(24);
      CNT_W'(3): c = COEF_W'(32);
      CNT_W'(4): c = COEF_W'(48);
      CNT_W'(5): c = COEF_W'(48);
      CNT_W'(6): c = COEF_W'(32);
      CNT_W'(7): c = COEF_W'(24);
      CNT_W'(8): c = COEF_W'(16);
      CNT_W'(9): c = COEF_W'(8);
      default:   c = COEF_W'(0);
    endcase
    return c;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             primed_q, primed_d;
  logic [X_W-1:0]   sample_y_q, sample_y_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;

  logic [X_W-1:0]   result_c;
  logic [ACC_W-1:0] prod_c;
  logic [ACC_W-1:0] prod0_c;

  // Output scaling of the closed frame's accumulator.
  always_comb begin
`ifdef DECIMATOR_10X_ROUND_EN
    result_c = X_W'((acc_q + ROUND_K) >> 8);
`else
    result_c = X_W'(acc_q >> 8);
`endif
  end

  // Tap products: current phase, and phase 0 for a sample that opens a frame.
  always_comb begin
    prod_c  = ACC_W'(sample_x) * ACC_W'(coef(cnt_q));
    prod0_c = ACC_W'(sample_x) * ACC_W'(coef(CNT_W'(0)));
  end

  // Next-state: frame close/open on clk_en, accumulate on clk_en_10x.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    primed_d    = primed_q;
    sample_y_d  = sample_y_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    if (clk_en) begin
      sample_y_d  = result_c;
      valid_d     = primed_q;
      frame_err_d = primed_q && (cnt_q != FRAME_LEN);
      primed_d    = 1'b1;
      if (clk_en_10x) begin
        acc_d = prod0_c;
        cnt_d = CNT_W'(1);
      end else begin
        acc_d = '0;
        cnt_d = '0;
      end
    end else if (clk_en_10x) begin
      if (cnt_q < FRAME_LEN) begin
        acc_d = acc_q + prod_c;
      end
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      primed_q    <= 1'b0;
      sample_y_q  <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      primed_q    <= primed_d;
      sample_y_q  <= sample_y_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign sample_y  = sample_y_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;

endmodule
